lsq_unit: RTL

Parametrised load/store unit for the out-of-order core, sitting between the reservation stations / ROB and the data memory port. It generalises the earlier fixed-width unit with:
- configurable data, address and ROB-tag widths;
- configurable store-queue depth and memory read latency;
- youngest-match store-to-load forwarding;
- a flush that preserves stores the ROB has already committed.

---
 rtl/lsu_pkg.sv | 24 ++
 rtl/lsq_unit_store_queue.sv | 125 ++++++++++++
 rtl/lsq_unit.sv | 109 ++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// lsq_unit shared package
// default geometry and entry/stage field layouts
package lsu_pkg;

  localparam int DATA_W_D   = 16;
  localparam int ADDR_W_D   = 16;
  localparam int ROB_W_D    = 6;
  localparam int SQ_DEPTH_D = 8;
  localparam int MEM_LAT_D  = 3;
  localparam int COMMIT_W_D = 2;

  // store entry flags; addr and data follow in that order
  typedef struct packed {
    logic valid;
    logic committed;
  } sq_flags_t;

  // load stage flags; rob and fwd_data follow in that order
  typedef struct packed {
    logic valid;
    logic fwd;
  } ld_flags_t;

endpackage

// File: rtl/lsq_unit_store_queue.sv
// store_queue: circular store buffer
// commit, drain, flush truncation, youngest-match search
module store_queue
  import lsu_pkg::*;
#(
  parameter int DATA_W   = DATA_W_D,
  parameter int ADDR_W   = ADDR_W_D,
  parameter int SQ_DEPTH = SQ_DEPTH_D,
  parameter int COMMIT_W = COMMIT_W_D
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                enq,
  input  logic [ADDR_W-1:0]   enq_addr,
  input  logic [DATA_W-1:0]   enq_data,
  input  logic [COMMIT_W-1:0] stores_to_commit,
  input  logic [ADDR_W-1:0]   ld_addr,
  output logic                full,
  output logic                hit,
  output logic [DATA_W-1:0]   hit_data,
  output logic                commit_valid,
  output logic [ADDR_W-1:0]   commit_addr,
  output logic [DATA_W-1:0]   commit_data
);

  localparam int PW = $clog2(SQ_DEPTH);

  typedef logic [PW:0]   ptr_t;
  typedef logic [PW-1:0] idx_t;

  typedef struct packed {
    sq_flags_t         f;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } sq_entry_t;

  sq_entry_t sq [SQ_DEPTH];

  ptr_t head;
  ptr_t cmt;
  ptr_t tail;
  ptr_t occ;
  ptr_t uncmt;
  ptr_t n_cmt;
  ptr_t cmt_nxt;
  idx_t hi;
  idx_t ti;
  idx_t si;
  logic drain;
  logic do_enq;
  logic [SQ_DEPTH-1:0] new_cmt;

  // occupancy, clamped commit count, drain and enqueue
  always_comb begin
    hi    = head[PW-1:0];
    ti    = tail[PW-1:0];
    occ   = tail - head;
    uncmt = tail - cmt;
    full  = (occ == ptr_t'(SQ_DEPTH));
    if (int'(stores_to_commit) < int'(uncmt))
      n_cmt = ptr_t'(stores_to_commit);
    else
      n_cmt = uncmt;
    cmt_nxt = cmt + n_cmt;
    for (int i = 0; i < SQ_DEPTH; i++) begin
      new_cmt[i] =
        ((i - int'(cmt[PW-1:0]) + SQ_DEPTH)
         % SQ_DEPTH) < int'(n_cmt);
    end
    drain  = sq[hi].f.valid && sq[hi].f.committed;
    do_enq = enq && !full && !flush;
  end

  // youngest match wins: scan oldest to youngest
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    si       = '0;
    for (int k = 0; k < SQ_DEPTH; k++) begin
      si = hi + idx_t'(k);
      if (sq[si].f.valid && sq[si].addr == ld_addr) begin
        hit      = 1'b1;
        hit_data = sq[si].data;
      end
    end
  end

  assign commit_valid = drain;
  assign commit_addr  = drain ? sq[hi].addr : '0;
  assign commit_data  = drain ? sq[hi].data : '0;

  // pointer and entry state update
  always_ff @(posedge clk) begin
    if (rst) begin
      head <= '0;
      cmt  <= '0;
      tail <= '0;
      for (int i = 0; i < SQ_DEPTH; i++)
        sq[i].f <= '0;
    end else begin
      cmt <= cmt_nxt;
      for (int i = 0; i < SQ_DEPTH; i++)
        if (new_cmt[i])
          sq[i].f.committed <= 1'b1;
      if (drain) begin
        sq[hi].f <= '0;
        head     <= head + ptr_t'(1);
      end
      if (flush) begin
        tail <= cmt_nxt;
        for (int i = 0; i < SQ_DEPTH; i++)
          if (!sq[i].f.committed && !new_cmt[i])
            sq[i].f.valid <= 1'b0;
      end else if (do_enq) begin
        sq[ti].f.valid     <= 1'b1;
        sq[ti].f.committed <= 1'b0;
        sq[ti].addr        <= enq_addr;
        sq[ti].data        <= enq_data;
        tail               <= tail + ptr_t'(1);
      end
    end
  end

endmodule

// File: rtl/lsq_unit.sv
// lsq_unit: load/store unit top
// fixed-latency load pipeline over the store queue
module lsq_unit
  import lsu_pkg::*;
#(
  parameter int DATA_W   = DATA_W_D,
  parameter int ADDR_W   = ADDR_W_D,
  parameter int ROB_W    = ROB_W_D,
  parameter int SQ_DEPTH = SQ_DEPTH_D,
  parameter int MEM_LAT  = MEM_LAT_D,
  parameter int COMMIT_W = COMMIT_W_D
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                in_valid,
  input  logic                in_is_ld,
  input  logic [ADDR_W-1:0]   in_addr,
  input  logic [DATA_W-1:0]   in_data,
  input  logic [ROB_W-1:0]    in_rob,
  output logic                in_stall,
  input  logic [COMMIT_W-1:0] stores_to_commit,
  output logic                commit_valid,
  output logic [ADDR_W-1:0]   commit_addr,
  output logic [DATA_W-1:0]   commit_data,
  output logic                mem_rd_valid,
  output logic [ADDR_W-1:0]   mem_rd_addr,
  input  logic [DATA_W-1:0]   mem_rd_data,
  output logic                out_valid,
  output logic [DATA_W-1:0]   out_data,
  output logic [ROB_W-1:0]    out_rob
);

  typedef struct packed {
    ld_flags_t         f;
    logic [ROB_W-1:0]  rob;
    logic [DATA_W-1:0] fwd_data;
  } ld_stage_t;

  ld_stage_t pipe [MEM_LAT];
  ld_stage_t ld_new;
  ld_stage_t last;

  logic ld_acc;
  logic sq_full;
  logic sq_hit;
  logic [DATA_W-1:0] sq_hit_data;

  store_queue #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .SQ_DEPTH (SQ_DEPTH),
    .COMMIT_W (COMMIT_W)
  ) u_sq (
    .clk              (clk),
    .rst              (rst),
    .flush            (flush),
    .enq              (in_valid && !in_is_ld),
    .enq_addr         (in_addr),
    .enq_data         (in_data),
    .stores_to_commit (stores_to_commit),
    .ld_addr          (in_addr),
    .full             (sq_full),
    .hit              (sq_hit),
    .hit_data         (sq_hit_data),
    .commit_valid     (commit_valid),
    .commit_addr      (commit_addr),
    .commit_data      (commit_data)
  );

  assign in_stall = sq_full;
  assign ld_acc   = in_valid && in_is_ld && !flush;

  // miss request and the entering load stage
  always_comb begin
    mem_rd_valid = ld_acc && !sq_hit;
    mem_rd_addr  = mem_rd_valid ? in_addr : '0;
    ld_new       = '0;
    if (ld_acc) begin
      ld_new.f.valid  = 1'b1;
      ld_new.f.fwd    = sq_hit;
      ld_new.rob      = in_rob;
      ld_new.fwd_data = sq_hit ? sq_hit_data : '0;
    end
  end

  // shift pipeline, cleared on reset or flush
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int i = 0; i < MEM_LAT; i++)
        pipe[i] <= '0;
    end else begin
      pipe[0] <= ld_new;
      for (int i = 1; i < MEM_LAT; i++)
        pipe[i] <= pipe[i-1];
    end
  end

  // result select: forwarded data or memory return
  always_comb begin
    last      = pipe[MEM_LAT-1];
    out_valid = last.f.valid;
    out_rob   = last.rob;
    out_data  = '0;
    if (last.f.valid)
      out_data = last.f.fwd ? last.fwd_data : mem_rd_data;
  end

endmodule
